tmr_vote_monitor: RTL
=====================

Name: tmr_vote_monitor

Overview:
- Single-clock collapse point for triplicated state. It is the reading end of a fanout→triplicated-register path.
- Takes three lane copies of a W-bit register, produces a registered bitwise-majority word and per-lane mismatch flags.
- Accumulates saturating per-lane upset counters and exposes them through a 4-phase snapshot-and-clear handshake to a slow-control reader.
- Placed wherever triplicated FSM/register state leaves the TMR domain.

Parameters:
- W, 8, width of each lane word
- CNT_W, 16, width of each per-lane upset counter

Ports:
- clk  in  1  single clock, all lanes sampled on posedge
- rstn  in  1  reset, synchronous, active-low
- inA  in  W  lane A copy
- inB  in  W  lane B copy
- inC  in  W  lane C copy
- sample_en  in  1  lanes valid this cycle
- voted  out  W  registered bitwise majority
- voted_vld  out  1  voted updated this cycle
- err_lane  out  3  registered per-lane mismatch {C,B,A}
- multi_err  out  1  more than one lane disagrees with voted word
- snap_req  in  1  reader request, 4-phase
- snap_ack  out  1  snapshot valid, 4-phase
- cntA  out  CNT_W  snapshot of lane A counter
- cntB  out  CNT_W  snapshot of lane B counter
- cntC  out  CNT_W  snapshot of lane C counter

Behaviour:
- Reset values (rstn low at posedge): voted=0, voted_vld=0, err_lane=0, multi_err=0, snap_ack=0, cntA/B/C=0, internal counters=0, FSM=IDLE. Reset mid-handshake drops snap_ack the next cycle. Reader must restart.
- Vote: maj[i] = (A&B)|(B&C)|(A&C) per bit. This is combinational. Registered into voted one cycle after sample_en. voted holds when sample_en=0.
- Lane mismatch: mmX = (inX != maj), word-wide OR-reduce. Registered into err_lane with the same latency as voted.
- Gating: err_lane, multi_err and voted_vld are 0 in cycles following sample_en=0.
- multi_err = 1 when popcount(mm) >= 2. Possible for W>1, e.g. A differs on bit0 and B on bit1.
- Counters: on sample_en and mmX, internal cntX_int += 1. It saturates at 2^CNT_W-1 and never wraps.
- Handshake FSM has states IDLE, ACK, WAIT_LOW.
  - IDLE & snap_req=1: the snapshot registers take cntX_int plus this cycle's increment, saturated. cntX_int is set to 0. Go to ACK.
  - ACK: snap_ack=1 from this cycle on. Stay until snap_req=0, then snap_ack=0 and go to WAIT_LOW.
  - WAIT_LOW: one idle cycle, then IDLE. snap_req=1 here is not accepted until IDLE.
- No event loss: an upset in the snapshot/clear cycle is in the snapshot. Upsets from the next cycle onward count from 0.
- Snapshot stability: snapshot outputs are held stable from snap_ack rise until the next accepted request.
- Counting during ACK and WAIT_LOW continues normally.

Decomposition:
- Shared package tmr_pkg holds:
  - enum of FSM states (IDLE, ACK, WAIT_LOW)
  - function maj3 (bitwise majority)
  - function sat_inc (saturating increment)
  - default widths W and CNT_W
- One natural sub-module: tmr_lane_counter (saturating counter with clear-and-snapshot), instantiated three times.
- Voting and the FSM stay in the top.

Test Plan:
1. Reset then W=8 lanes A=B=C=8'h5A with sample_en=1 → next cycle voted=8'h5A, voted_vld=1, err_lane=3'b000, multi_err=0. Counters stay 0.
2. A=8'h5B, B=C=8'h5A for 3 cycles, then snap_req=1 → voted=8'h5A, err_lane=3'b001 each cycle. Snapshot cntA=3, cntB=0, cntC=0. snap_ack rises the cycle after the request is sampled.
3. A=8'h01, B=8'h02, C=8'h00 → voted=8'h00, err_lane=3'b011, multi_err=1.
4. CNT_W=4, lane C upset for 20 cycles, then snapshot → cntC=15 (saturated, no wrap). Next snapshot with no upsets gives cntC=0.
5. snap_req sampled in the same cycle as a lane B upset, with cntB_int=4 → cntB snapshot=5. Internal count restarts at 0 and is 0 at the next snapshot if no further upsets.
6. rstn low while snap_ack=1 → snap_ack=0 and cnt outputs=0 after that posedge. snap_req held high through reset is accepted from IDLE after rstn releases.

Source files
------------

// File: rtl/tmr_vote_monitor_pkg.sv
// rtl/tmr_vote_monitor_pkg.sv - shared types, widths and helpers for the TMR vote monitor
package tmr_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_W     = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } snapState_t;

  function automatic logic [MAX_W-1:0] maj3(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b,
                                            input logic [MAX_W-1:0] c);
    return (a & b) | (b & c) | (a & c);
  endfunction

  // Increment that sticks at 2^w-1 instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] maxV;
    maxV = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= maxV) ? maxV : v + 32'd1;
  endfunction

endpackage

// File: rtl/tmr_vote_monitor_if.sv
// rtl/tmr_vote_monitor_if.sv - lane inputs, voted outputs and snapshot handshake bundle
interface tmr_vote_monitor_if #(
  parameter int W     = tmr_pkg::DEF_W,
  parameter int CNT_W = tmr_pkg::DEF_CNT_W
);
  logic [W-1:0]     inA;
  logic [W-1:0]     inB;
  logic [W-1:0]     inC;
  logic             sample_en;
  logic [W-1:0]     voted;
  logic             voted_vld;
  logic [2:0]       err_lane;
  logic             multi_err;
  logic             snap_req;
  logic             snap_ack;
  logic [CNT_W-1:0] cntA;
  logic [CNT_W-1:0] cntB;
  logic [CNT_W-1:0] cntC;

  modport master (
    output inA, inB, inC, sample_en, snap_req,
    input  voted, voted_vld, err_lane, multi_err, snap_ack, cntA, cntB, cntC
  );

  modport slave (
    input  inA, inB, inC, sample_en, snap_req,
    output voted, voted_vld, err_lane, multi_err, snap_ack, cntA, cntB, cntC
  );
endinterface

// File: rtl/tmr_vote_monitor_lane_counter.sv
// rtl/tmr_vote_monitor_lane_counter.sv - saturating upset counter with atomic snapshot-and-clear
module tmr_lane_counter
  import tmr_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             upset,
  input  logic             snap,
  output logic [CNT_W-1:0] snapVal
);

  logic [CNT_W-1:0] cntInt;
  logic [CNT_W-1:0] nextCnt;

  always_comb begin
    nextCnt = cntInt;
    if (upset) nextCnt = CNT_W'(sat_inc(32'(cntInt), CNT_W));
  end

  // The snapshot captures this cycle's upset too, so clearing never drops an event.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cntInt  <= '0;
      snapVal <= '0;
    end else if (snap) begin
      cntInt  <= '0;
      snapVal <= nextCnt;
    end else begin
      cntInt  <= nextCnt;
    end
  end

endmodule

// File: rtl/tmr_vote_monitor.sv
// rtl/tmr_vote_monitor.sv - majority voter, lane mismatch flags and upset counter snapshot handshake
module tmr_vote_monitor
  import tmr_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                clk,
  input logic                rstn,
  tmr_vote_monitor_if.slave  bus
);

  logic [W-1:0] maj;
  logic [2:0]   mm;
  logic         multi;
  logic         snap;
  snapState_t   state;

  always_comb begin
    maj   = W'(maj3(MAX_W'(bus.inA), MAX_W'(bus.inB), MAX_W'(bus.inC)));
    mm    = {bus.inC != maj, bus.inB != maj, bus.inA != maj};
    multi = (mm[0] & mm[1]) | (mm[1] & mm[2]) | (mm[0] & mm[2]);
    snap  = (state == IDLE) && bus.snap_req;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.voted     <= '0;
      bus.voted_vld <= 1'b0;
      bus.err_lane  <= 3'b000;
      bus.multi_err <= 1'b0;
    end else begin
      bus.voted_vld <= bus.sample_en;
      bus.err_lane  <= bus.sample_en ? mm : 3'b000;
      bus.multi_err <= bus.sample_en & multi;
      if (bus.sample_en) bus.voted <= maj;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      bus.snap_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.snap_req) begin
          state        <= ACK;
          bus.snap_ack <= 1'b1;
        end
        ACK: if (!bus.snap_req) begin
          state        <= WAIT_LOW;
          bus.snap_ack <= 1'b0;
        end
        WAIT_LOW: state <= IDLE;
        default: begin
          state        <= IDLE;
          bus.snap_ack <= 1'b0;
        end
      endcase
    end
  end

  tmr_lane_counter #(.CNT_W(CNT_W)) uCntA (
    .clk(clk), .rstn(rstn), .upset(bus.sample_en & mm[0]), .snap(snap), .snapVal(bus.cntA)
  );
  tmr_lane_counter #(.CNT_W(CNT_W)) uCntB (
    .clk(clk), .rstn(rstn), .upset(bus.sample_en & mm[1]), .snap(snap), .snapVal(bus.cntB)
  );
  tmr_lane_counter #(.CNT_W(CNT_W)) uCntC (
    .clk(clk), .rstn(rstn), .upset(bus.sample_en & mm[2]), .snap(snap), .snapVal(bus.cntC)
  );

endmodule
